xbus_copy: RTL

XBUS_COPY -- requirements
Module: xbus_copy

---
 rtl/xbus_copy_pkg.sv | 32 +++
 rtl/xbus_copy.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/xbus_copy_pkg.sv
// Shared definitions for the xbus_copy block-copy engine.
// The bus widths and FSM state encodings normally come from the shared
// xdefs.vh; the guarded defaults below keep this slice self-contained and
// yield to any earlier definition from that header.
// Optional feature macro used by xbus_copy: XBUS_COPY_CHECKSUM_EN.

`ifndef DATA_W
`define DATA_W 32
`endif

`ifndef REGF_ADDR_W
`define REGF_ADDR_W 4
`endif

`ifndef XBUS_COPY_IDLE
`define XBUS_COPY_IDLE  2'd0
`define XBUS_COPY_READ  2'd1
`define XBUS_COPY_WRITE 2'd2
`define XBUS_COPY_DONE  2'd3
`endif

package xbus_copy_pkg;

    // Copy engine states: one read then one write per word, then a done pulse.
    typedef enum logic [1:0] {
        S_IDLE  = `XBUS_COPY_IDLE,
        S_READ  = `XBUS_COPY_READ,
        S_WRITE = `XBUS_COPY_WRITE,
        S_DONE  = `XBUS_COPY_DONE
    } state_t;

endpackage

// File: rtl/xbus_copy.sv
// xbus_copy: copies len words from src to dst over a simple register-file bus,
// one word every two cycles, ascending, each word read before it is written.
// Optional feature: define XBUS_COPY_CHECKSUM_EN to add a running checksum
// of the copied words on the checksum port.

module xbus_copy
    import xbus_copy_pkg::*;
#(
    parameter int DATA_W = `DATA_W,
    parameter int ADDR_W = `REGF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              m_sel,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
`ifdef XBUS_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W:0]     r_cnt;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_lastAddr;
    logic [DATA_W-1:0]   r_lastWdata;
    logic                w_accept;

    // A start is only honoured in IDLE; len=0 still counts as accepted.
    assign w_accept = (r_state == S_IDLE) && start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pointers, remaining count, captured word and held bus values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_lastAddr  <= '0;
            r_lastWdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (len != '0)) begin
                        r_src <= src;
                        r_dst <= dst;
                        r_cnt <= len;
                    end
                end
                S_READ: begin
                    r_data     <= m_rdata;
                    r_lastAddr <= r_src;
                end
                S_WRITE: begin
                    r_src       <= r_src + ADDR_W'(1);
                    r_dst       <= r_dst + ADDR_W'(1);
                    r_cnt       <= r_cnt - (ADDR_W + 1)'(1);
                    r_lastAddr  <= r_dst;
                    r_lastWdata <= r_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and bus outputs; address/data hold their last values when idle.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        m_sel       = 1'b0;
        m_we        = 1'b0;
        m_addr      = r_lastAddr;
        m_wdata     = r_lastWdata;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                m_sel       = 1'b1;
                m_addr      = r_src;
                w_nextState = S_WRITE;
            end
            S_WRITE: begin
                m_sel       = 1'b1;
                m_we        = 1'b1;
                m_addr      = r_dst;
                m_wdata     = r_data;
                w_nextState = (r_cnt == (ADDR_W + 1)'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

`ifdef XBUS_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of captured words, cleared by each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_state == S_READ) begin
            r_checksum <= r_checksum + m_rdata;
        end
    end

    assign checksum = r_checksum;
`else
    logic w_unusedAccept;
    assign w_unusedAccept = w_accept;
`endif

endmodule
